rle_run_decoder: RTL and testbench
==================================

RLE_RUN_DECODER -- requirements
Module: rle_run_decoder

Interface
REQ-001 Parameter RUN_W, default 11, SHALL set the bit width of each run-length word and of the run counter.
REQ-002 Parameter NUM_RUNS, default 3, minimum 1, SHALL set the number of run-length words decoded per image.
REQ-003 Parameter IDX_W, default 2, SHALL set the width of run_idx and SHALL satisfy 2^IDX_W >= NUM_RUNS+1.
REQ-004 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 runs  input  NUM_RUNS*RUN_W  SHALL carry the run lengths, with run k at bits [k*RUN_W +: RUN_W] and run 0 decoded first.
REQ-007 new_im  input  1  SHALL be the load strobe that captures runs and first_sym and restarts decoding.
REQ-008 first_sym  input  1  SHALL be the symbol value emitted for run 0.
REQ-009 enable  input  1  SHALL be the advance qualifier; decoding progresses only in cycles where it is high.
REQ-010 sym  output  1  SHALL be the decoded symbol.
REQ-011 sym_valid  output  1  SHALL be high for exactly one cycle per emitted symbol.
REQ-012 run_idx  output  IDX_W  SHALL give the index of the run currently being decoded.
REQ-013 done  output  1  SHALL be high while all runs of the current image are exhausted.
REQ-014 busy  output  1  SHALL be high while in state RUN.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-016 new_im SHALL have priority over all other activity in every state, enable not required: it captures runs into internal registers, sets idx=0, cnt=0, cur_sym=first_sym and sym_valid=0, and enters RUN.
REQ-017 In RUN with enable=1 and run[idx]!=0, the block SHALL register sym<=cur_sym and sym_valid<=1.
REQ-018 In that same case, if cnt+1==run[idx], the block SHALL set cnt<=0, idx<=idx+1 and cur_sym<=~cur_sym; otherwise it SHALL set cnt<=cnt+1.
REQ-019 In RUN with enable=1 and run[idx]==0, the block SHALL spend exactly one cycle with sym_valid<=0, set idx<=idx+1 and set cur_sym<=~cur_sym, so that zero-length runs preserve symbol alternation.
REQ-020 When idx advances past NUM_RUNS-1, the next state SHALL be DONE.
REQ-021 In RUN with enable=0, the block SHALL hold all state and drive sym_valid<=0.
REQ-022 Latency from an accepted enable cycle to the corresponding sym_valid SHALL be exactly 1 cycle.
REQ-023 sym SHALL hold its last value when sym_valid=0.
REQ-024 Over one image, the total sym_valid pulses SHALL equal the sum of all runs; the count SHALL be independent of enable gaps.
REQ-025 Run length arithmetic SHALL be unsigned RUN_W-bit, and a run of 2^RUN_W-1 SHALL emit exactly that many symbols with no counter wrap.
REQ-026 In DONE, the block SHALL hold done=1 and sym_valid=0 until new_im or reset.
REQ-027 In IDLE, the block SHALL ignore enable.
REQ-028 A new_im during RUN SHALL abort the current image immediately; the next emitted symbol SHALL belong to the new image's run 0.
REQ-029 When new_im and enable are high in the same cycle, only the load SHALL take effect, and sym_valid SHALL be 0 in the following cycle.
REQ-030 Changes on runs and first_sym outside new_im cycles SHALL have no effect on decoding.
REQ-031 run_idx SHALL equal idx and SHALL read NUM_RUNS in DONE.

Reset
REQ-032 Assertion of RESET_N=0 SHALL asynchronously force state IDLE, idx=0, cnt=0, cur_sym=0, sym=0, sym_valid=0, done=0, busy=0 and run_idx=0, and clear the captured run registers to 0.
REQ-033 After RESET_N deassertion, the block SHALL remain in IDLE until the first new_im.
REQ-034 Reset asserted mid-RUN SHALL discard the image in progress, and no sym_valid SHALL occur until a new load.

Verification
REQ-035 Basic decode: runs={2,3,1} (run 0 first), first_sym=0, new_im pulse, then enable held high -> sym sequence 0,0,1,1,1,0 on 6 consecutive sym_valid cycles, followed by done=1 and run_idx=3.
REQ-036 Zero-length runs: runs={0,2,0}, first_sym=1 -> exactly two sym_valid pulses, both sym=0; one idle cycle each before and after them; then done=1.
REQ-037 Enable gaps: runs={3,1,2}, enable toggling 1,0,1,0,... -> the same sequence 0,0,0,1,0,0, with each sym_valid exactly 1 cycle after an enable=1 cycle.
REQ-038 Maximum run: RUN_W=4, runs={15,1,1} -> 15 pulses of first_sym, then 1 inverted, then 1 original; 17 pulses in total; no wrap.
REQ-039 Abort and priority: new_im asserted together with enable on the 3rd symbol of runs={5,5,5} -> sym_valid=0 in the next cycle, then the new image decodes from run 0 with the newly captured first_sym.
REQ-040 Async reset: RESET_N pulled low between clock edges mid-RUN -> all outputs 0 immediately; after release, enable alone produces no sym_valid until new_im.

Source files
------------

// File: rtl/rle_run_decoder.sv
// Run-length decoder: expands NUM_RUNS captured run lengths into an alternating
// one-bit symbol stream, one symbol per enabled cycle.
module rle_run_decoder #(
  parameter int unsigned RUN_W    = 11,
  parameter int unsigned NUM_RUNS = 3,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_RUNS*RUN_W-1:0] runs,
  input  logic                      new_im,
  input  logic                      first_sym,
  input  logic                      enable,
  output logic                      sym,
  output logic                      sym_valid,
  output logic [IDX_W-1:0]          run_idx,
  output logic                      done,
  output logic                      busy
);

  // Run table is sized to the full index space so idx never selects past it.
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_q [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic [RUN_W-1:0]   cnt;
  logic               cur_sym;

  logic [RUN_W-1:0]   cur_run;
  logic               zero_run;
  logic               run_end;
  logic               last_run;
  logic               advance;

  assign cur_run  = run_q[idx];
  assign zero_run = (cur_run == '0);
  assign run_end  = (RUN_W'(cnt + RUN_W'(1)) == cur_run);
  assign last_run = (idx == IDX_W'(NUM_RUNS - 1));
  // A zero-length run still consumes one enabled cycle so the symbol flips.
  assign advance  = enable & (zero_run | run_end);

  assign run_idx  = idx;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      cur_sym   <= 1'b0;
      sym       <= 1'b0;
      sym_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        run_q[k] <= '0;
      end
    end else if (new_im) begin
      for (int k = 0; k < int'(NUM_RUNS); k++) begin
        run_q[k] <= runs[k*RUN_W +: RUN_W];
      end
      for (int k = int'(NUM_RUNS); k < int'(DEPTH); k++) begin
        run_q[k] <= '0;
      end
      state     <= RUN;
      idx       <= '0;
      cnt       <= '0;
      cur_sym   <= first_sym;
      sym_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        RUN: begin
          if (enable && !zero_run) begin
            sym       <= cur_sym;
            sym_valid <= 1'b1;
            if (!run_end) begin
              cnt <= cnt + RUN_W'(1);
            end
          end
          if (advance) begin
            cnt     <= '0;
            idx     <= idx + IDX_W'(1);
            cur_sym <= ~cur_sym;
            if (last_run) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_run_decoder.sv
// Directed bench for rle_run_decoder with RUN_W=4 so the maximum run is reachable.
module tb_rle_run_decoder;

  localparam int unsigned RUN_W    = 4;
  localparam int unsigned NUM_RUNS = 3;
  localparam int unsigned IDX_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_RUNS*RUN_W-1:0] runs;
  logic                      new_im;
  logic                      first_sym;
  logic                      enable;
  logic                      sym;
  logic                      sym_valid;
  logic [IDX_W-1:0]          run_idx;
  logic                      done;
  logic                      busy;

  int n_checks;
  int n_errors;

  logic [31:0] vmask;
  logic [31:0] symseq;
  int          nsym;

  rle_run_decoder #(
    .RUN_W   (RUN_W),
    .NUM_RUNS(NUM_RUNS),
    .IDX_W   (IDX_W)
  ) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .runs     (runs),
    .new_im   (new_im),
    .first_sym(first_sym),
    .enable   (enable),
    .sym      (sym),
    .sym_valid(sym_valid),
    .run_idx  (run_idx),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_RUNS*RUN_W-1:0] pack(input int r0, input int r1, input int r2);
    return {RUN_W'(r2), RUN_W'(r1), RUN_W'(r0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NUM_RUNS*RUN_W-1:0] r, input logic fs, input logic en);
    runs      = r;
    first_sym = fs;
    enable    = en;
    new_im    = 1'b1;
    step();
    new_im = 1'b0;
    enable = 1'b0;
  endtask

  // Runs n cycles with enable from en_mask; logs valid cycles and emitted symbols.
  task automatic collect(input int n, input logic [31:0] en_mask,
                         output logic [31:0] vm, output logic [31:0] ss, output int cnt);
    vm  = '0;
    ss  = '0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      enable = en_mask[i];
      step();
      if (sym_valid === 1'b1) begin
        vm[i]   = 1'b1;
        ss[cnt] = sym;
        cnt++;
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    runs      = '0;
    new_im    = 1'b0;
    first_sym = 1'b0;
    enable    = 1'b0;

    #2;
    check("rst_sym", 32'(sym), 32'd0);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(run_idx), 32'd0);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Enable alone does nothing before the first load.
    collect(4, 32'hF, vmask, symseq, nsym);
    check("idle_pulses", 32'(nsym), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic decode {2,3,1}, first_sym 0.
    load(pack(2, 3, 1), 1'b0, 1'b0);
    check("basic_load_busy", 32'(busy), 32'd1);
    check("basic_load_valid", 32'(sym_valid), 32'd0);
    check("basic_load_idx", 32'(run_idx), 32'd0);
    collect(8, 32'hFF, vmask, symseq, nsym);
    check("basic_count", 32'(nsym), 32'd6);
    check("basic_vmask", vmask, 32'h3F);
    check("basic_syms", symseq, 32'h1C);
    check("basic_done", 32'(done), 32'd1);
    check("basic_idx", 32'(run_idx), 32'd3);
    check("basic_busy", 32'(busy), 32'd0);

    // Zero-length runs {0,2,0}, first_sym 1.
    load(pack(0, 2, 0), 1'b1, 1'b0);
    collect(6, 32'h3F, vmask, symseq, nsym);
    check("zero_count", 32'(nsym), 32'd2);
    check("zero_vmask", vmask, 32'h06);
    check("zero_syms", symseq, 32'h0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_sym_hold", 32'(sym), 32'd0);

    // Enable gaps {3,1,2}, enable 1,0,1,0...
    load(pack(3, 1, 2), 1'b0, 1'b0);
    collect(14, 32'h1555, vmask, symseq, nsym);
    check("gap_count", 32'(nsym), 32'd6);
    check("gap_vmask", vmask, 32'h555);
    check("gap_syms", symseq, 32'h08);
    check("gap_done", 32'(done), 32'd1);

    // Maximum run {15,1,1}, first_sym 1.
    load(pack(15, 1, 1), 1'b1, 1'b0);
    collect(20, 32'hFFFFF, vmask, symseq, nsym);
    check("max_count", 32'(nsym), 32'd17);
    check("max_vmask", vmask, 32'h1FFFF);
    check("max_syms", symseq, 32'h17FFF);
    check("max_done", 32'(done), 32'd1);
    check("max_idx", 32'(run_idx), 32'd3);

    // Abort: new_im with enable on the 3rd symbol of {5,5,5}.
    load(pack(5, 5, 5), 1'b0, 1'b0);
    collect(2, 32'h3, vmask, symseq, nsym);
    check("abort_pre_count", 32'(nsym), 32'd2);
    load(pack(2, 1, 1), 1'b1, 1'b1);
    check("abort_valid", 32'(sym_valid), 32'd0);
    check("abort_idx", 32'(run_idx), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    runs      = pack(7, 7, 7);
    first_sym = 1'b0;
    collect(6, 32'h3F, vmask, symseq, nsym);
    check("abort_count", 32'(nsym), 32'd4);
    check("abort_vmask", vmask, 32'h0F);
    check("abort_syms", symseq, 32'h0B);
    check("abort_done", 32'(done), 32'd1);

    // Asynchronous reset mid-run.
    load(pack(5, 5, 5), 1'b1, 1'b0);
    collect(2, 32'h3, vmask, symseq, nsym);
    check("ar_pre_count", 32'(nsym), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("ar_sym", 32'(sym), 32'd0);
    check("ar_valid", 32'(sym_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_idx", 32'(run_idx), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    collect(5, 32'h1F, vmask, symseq, nsym);
    check("ar_post_count", 32'(nsym), 32'd0);
    check("ar_post_busy", 32'(busy), 32'd0);
    load(pack(1, 1, 1), 1'b0, 1'b0);
    collect(5, 32'h1F, vmask, symseq, nsym);
    check("ar_reload_count", 32'(nsym), 32'd3);
    check("ar_reload_syms", symseq, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
